// File: rtl/stack_cpu_core.sv
// 16-bit multi-cycle stack-machine CPU: FSM controller, shared internal bus, register file.
// The stack lives in external memory and grows downward from mem_max.
module stack_cpu_core (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] mem_rdata,
   input  logic [15:0] mem_max,
   output logic [15:0] mar,
   output logic [15:0] mdr,
   output logic        mrw,
   output logic        halted
);
   localparam int unsigned WIDTH = 16;
   localparam int unsigned NREGS = 8;

   typedef enum logic [3:0] {
      S_FETCH0, S_FETCH1, S_DECODE, S_PUSH_B, S_POP_PC, S_POP_R, S_ALU1,
      S_ALU2, S_DUP1, S_TEST1, S_TEST2, S_COPY1, S_HALT
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_pc, r_sp, r_mar, r_mdr, r_isr, r_y;
   logic [WIDTH-1:0]   r_regs [NREGS];
   logic               r_cc, r_mrw, r_halted;

   logic [3:0]         w_op;
   logic               w_sub;
   logic [2:0]         w_r;
   logic [WIDTH-1:0]   w_imm, w_sp_inc, w_sp_inc2, w_alu, w_bus;

   assign w_op      = r_isr[15:12];
   assign w_sub     = r_isr[11];
   assign w_r       = r_isr[10:8];
   assign w_imm     = {{4{r_isr[11]}}, r_isr[11:0]};
   assign w_sp_inc  = r_sp + 16'd1;
   assign w_sp_inc2 = r_sp + 16'd2;

   assign mar    = r_mar;
   assign mdr    = r_mdr;
   assign mrw    = r_mrw;
   assign halted = r_halted;

   // ALU: a is always the word just read from memory, b the latched Y
   always_comb begin
      w_alu = '0;
      case (w_r)
         3'd0:    w_alu = mem_rdata + r_y;
         3'd1:    w_alu = mem_rdata - r_y;
         3'd2:    w_alu = mem_rdata & r_y;
         3'd3:    w_alu = mem_rdata | r_y;
         3'd4:    w_alu = mem_rdata ^ r_y;
         3'd5:    w_alu = ~mem_rdata;
         3'd6:    w_alu = {mem_rdata[14:0], 1'b0};
         default: w_alu = r_y;
      endcase
   end

   // Internal bus: exactly one source per state
   always_comb begin
      w_bus = '0;
      case (r_state)
         S_FETCH0: w_bus = r_pc;
         S_DECODE: begin
            case (w_op)
               4'h9:    w_bus = r_pc;
               4'hB:    w_bus = w_imm;
               4'hD:    w_bus = r_regs[w_r];
               default: w_bus = '0;
            endcase
         end
         S_ALU2: w_bus = w_alu;
         S_FETCH1, S_POP_PC, S_POP_R, S_ALU1, S_DUP1, S_TEST1, S_COPY1:
            w_bus = mem_rdata;
         default: w_bus = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_FETCH0;
         r_pc     <= '0;
         r_sp     <= mem_max;
         r_mar    <= '0;
         r_mdr    <= '0;
         r_isr    <= '0;
         r_y      <= '0;
         r_cc     <= 1'b0;
         r_mrw    <= 1'b0;
         r_halted <= 1'b0;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         case (r_state)
            S_FETCH0: begin
               r_mar   <= w_bus;
               r_state <= S_FETCH1;
            end
            S_FETCH1: begin
               r_isr   <= w_bus;
               r_pc    <= r_pc + 16'd1;
               r_state <= S_DECODE;
            end
            S_DECODE: begin
               r_state <= S_FETCH0;
               case (w_op)
                  4'h0: begin
                     r_halted <= 1'b1;
                     r_state  <= S_HALT;
                  end
                  4'h4: if (!r_cc) r_pc <= r_pc + w_imm;
                  4'h9: begin
                     r_mar   <= r_sp;
                     r_mdr   <= w_bus;
                     r_mrw   <= 1'b1;
                     r_pc    <= r_pc + w_imm;
                     r_state <= S_PUSH_B;
                  end
                  4'hA: begin
                     r_sp    <= w_sp_inc;
                     r_mar   <= w_sp_inc;
                     r_state <= S_POP_PC;
                  end
                  4'hB: begin
                     r_mar   <= r_sp;
                     r_mdr   <= w_bus;
                     r_mrw   <= 1'b1;
                     r_state <= S_PUSH_B;
                  end
                  4'hC: begin
                     r_sp    <= w_sp_inc;
                     r_mar   <= w_sp_inc;
                     r_state <= w_sub ? S_POP_R : S_ALU1;
                  end
                  4'hD: begin
                     if (w_sub) begin
                        r_mar   <= w_sp_inc;
                        r_state <= S_DUP1;
                     end else begin
                        r_mar   <= r_sp;
                        r_mdr   <= w_bus;
                        r_mrw   <= 1'b1;
                        r_state <= S_PUSH_B;
                     end
                  end
                  4'hE: begin
                     r_mar   <= w_sp_inc;
                     r_state <= w_sub ? S_COPY1 : S_TEST1;
                  end
                  default: r_state <= S_FETCH0;
               endcase
            end
            // Memory commits mdr at the edge ending this cycle
            S_PUSH_B: begin
               r_mrw   <= 1'b0;
               r_sp    <= r_sp - 16'd1;
               r_state <= S_FETCH0;
            end
            S_POP_PC: begin
               r_pc    <= w_bus;
               r_state <= S_FETCH0;
            end
            S_POP_R: begin
               r_regs[w_r] <= w_bus;
               r_state     <= S_FETCH0;
            end
            S_ALU1: begin
               r_y     <= w_bus;
               r_sp    <= w_sp_inc;
               r_mar   <= w_sp_inc;
               r_state <= S_ALU2;
            end
            S_ALU2: begin
               r_cc    <= (w_alu == '0);
               r_mar   <= r_sp;
               r_mdr   <= w_bus;
               r_mrw   <= 1'b1;
               r_state <= S_PUSH_B;
            end
            S_DUP1: begin
               r_mdr   <= w_bus;
               r_mar   <= r_sp;
               r_mrw   <= 1'b1;
               r_state <= S_PUSH_B;
            end
            S_TEST1: begin
               r_y     <= w_bus;
               r_mar   <= w_sp_inc2;
               r_state <= S_TEST2;
            end
            S_TEST2: begin
               r_cc    <= (w_alu == '0);
               r_state <= S_FETCH0;
            end
            S_COPY1: begin
               r_regs[w_r] <= w_bus;
               r_state     <= S_FETCH0;
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_FETCH0;
         endcase
      end
   end
endmodule

// File: tb/tb_stack_cpu_core.sv
// Scoreboard bench for stack_cpu_core: an instruction-level reference model predicts every
// memory write; a monitor checks each mrw cycle against the predicted queue.
module tb_stack_cpu_core;
   logic        clk;
   logic        reset;
   logic [15:0] mem_rdata, mem_max, mar, mdr;
   logic        mrw, halted;

   stack_cpu_core dut (
      .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_max(mem_max),
      .mar(mar), .mdr(mdr), .mrw(mrw), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External memory: combinational read, posedge write; bench loads through the same port
   logic [15:0] mem [65536];
   logic        ld_en;
   logic [15:0] ld_a, ld_d;
   assign mem_rdata = mem[mar];
   always @(posedge clk) begin
      if (ld_en) mem[ld_a] <= ld_d;
      else if (mrw) mem[mar] <= mdr;
   end

   typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;
   wr_t         exp_q[$];
   int          errors, checks;
   bit          mon_en;
   logic [15:0] prog[$];

   // Reference model state
   logic [15:0] mm [65536];
   logic [15:0] m_regs [8];
   logic [15:0] m_pc, m_sp;
   logic        m_cc, m_halted;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] alu_ref(input logic [2:0] f, input logic [15:0] a,
                                           input logic [15:0] b);
      case (f)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return a * 16'd2;
         default: return b;
      endcase
   endfunction

   function automatic void mpush(input logic [15:0] v);
      mm[m_sp] = v;
      exp_q.push_back('{a: m_sp, d: v});
      m_sp = m_sp - 16'd1;
   endfunction

   function automatic logic [15:0] mpop();
      m_sp = m_sp + 16'd1;
      return mm[m_sp];
   endfunction

   task automatic run_model(input logic [15:0] mmax);
      logic [15:0] ins, imm, a, b, res, t1, t2;
      int          s;
      exp_q.delete();
      for (int i = 0; i < 65536; i++) mm[i] = mem[i];
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_pc = '0; m_sp = mmax; m_cc = 1'b0; m_halted = 1'b0;
      for (int step = 0; step < 5000 && !m_halted; step++) begin
         ins  = mm[m_pc];
         m_pc = m_pc + 16'd1;
         s    = int'(ins[11:0]);
         if (s >= 2048) s = s - 4096;
         imm  = 16'(s);
         t1   = m_sp + 16'd1;
         t2   = m_sp + 16'd2;
         case (ins[15:12])
            4'h0: m_halted = 1'b1;
            4'h4: if (!m_cc) m_pc = m_pc + imm;
            4'h9: begin mpush(m_pc); m_pc = m_pc + imm; end
            4'hA: m_pc = mpop();
            4'hB: mpush(imm);
            4'hC: begin
               if (ins[11]) m_regs[ins[10:8]] = mpop();
               else begin
                  b = mpop(); a = mpop();
                  res = alu_ref(ins[10:8], a, b);
                  m_cc = (res == 16'd0);
                  mpush(res);
               end
            end
            4'hD: if (ins[11]) mpush(mm[t1]); else mpush(m_regs[ins[10:8]]);
            4'hE: begin
               if (ins[11]) m_regs[ins[10:8]] = mm[t1];
               else m_cc = (alu_ref(ins[10:8], mm[t2], mm[t1]) == 16'd0);
            end
            default: ;
         endcase
      end
   endtask

   task automatic load_word(input logic [15:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_a = a; ld_d = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic run_prog(input logic [15:0] mmax);
      bit done;
      logic [15:0] pc_frz;
      @(negedge clk);
      mon_en = 1'b0; reset = 1'b1; mem_max = mmax;
      for (int i = 0; i < prog.size(); i++) load_word(16'(i), prog[i]);
      @(negedge clk);
      chk("reset_mrw", 32'(mrw), 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);
      chk("reset_pc", 32'(dut.r_pc), 32'd0);
      chk("reset_sp", 32'(dut.r_sp), 32'(mmax));
      run_model(mmax);
      mon_en = 1'b1; reset = 1'b0;
      @(negedge clk);
      chk("first_mar", 32'(mar), 32'd0);
      done = 1'b0;
      for (int c = 0; c < 5000 && !done; c++) begin
         @(negedge clk);
         if (halted) done = 1'b1;
      end
      chk("halt_reached", 32'(done), 32'(m_halted));
      chk("writes_pending", 32'(exp_q.size()), 32'd0);
      chk("final_pc", 32'(dut.r_pc), 32'(m_pc));
      chk("final_sp", 32'(dut.r_sp), 32'(m_sp));
      pc_frz = dut.r_pc;
      repeat (6) @(negedge clk);
      chk("halt_sticky", {15'd0, halted, mrw, dut.r_pc}, {15'd0, 1'b1, 1'b0, m_pc});
      chk("halt_frozen_pc", 32'(dut.r_pc), 32'(pc_frz));
      mon_en = 1'b0;
   endtask

   task automatic build_random(input int n);
      int d, k;
      logic [3:0] nop_ops [8];
      nop_ops = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF};
      prog.delete();
      d = 0;
      for (int i = 0; i < n; i++) begin
         k = $urandom_range(0, 8);
         if ((k == 2 || k == 3 || k == 4) && d < 1) k = 0;
         if ((k == 5 || k == 6) && d < 2) k = 0;
         case (k)
            1: begin prog.push_back({4'hD, 1'b0, 3'($urandom), 8'($urandom)}); d++; end
            2: begin prog.push_back({4'hD, 1'b1, 11'($urandom)}); d++; end
            3: begin prog.push_back({4'hC, 1'b1, 3'($urandom), 8'($urandom)}); d--; end
            4: prog.push_back({4'hE, 1'b1, 3'($urandom), 8'($urandom)});
            5: begin prog.push_back({4'hC, 1'b0, 3'($urandom), 8'($urandom)}); d--; end
            6: prog.push_back({4'hE, 1'b0, 3'($urandom), 8'($urandom)});
            7: begin
               prog.push_back(16'h4001);
               prog.push_back({nop_ops[$urandom_range(0, 7)], 12'($urandom)});
            end
            default: begin prog.push_back({4'hB, 12'($urandom)}); d++; end
         endcase
      end
      prog.push_back({4'h0, 12'($urandom)});
   endtask

   // Monitor: every write cycle must match the next predicted write
   always @(negedge clk) begin
      if (mon_en && !reset && mrw) begin
         wr_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mar, mdr);
         end else begin
            e = exp_q.pop_front();
            if ({mar, mdr} !== {e.a, e.d}) begin
               errors++;
               $display("FAIL mem_write: got addr=%h data=%h expected addr=%h data=%h",
                        mar, mdr, e.a, e.d);
            end
         end
      end
   end

   initial begin
      bit seen;
      logic [15:0] mmax_opts [3];
      errors = 0; checks = 0; mon_en = 1'b0;
      ld_en = 1'b0; ld_a = '0; ld_d = '0;
      reset = 1'b1; mem_max = 16'd4095;
      mmax_opts = '{16'd4095, 16'hFFFF, 16'd2047};

      // Countdown loop, call/return, DUP/COPY/TEST/ALU, then HALT
      prog = '{16'hB003, 16'hB001, 16'hC100, 16'hD800, 16'hCB00, 16'h4FFB,
               16'h9002, 16'hD300, 16'h0FFF, 16'hB7F0, 16'hEC00, 16'hD400,
               16'hE200, 16'hC400, 16'hCE00, 16'hA000};
      run_prog(16'd4095);

      // Reset asserted while a push is committing must drop the write
      prog = '{16'hB00C, 16'h0FFF};
      run_prog(16'd4095);
      @(negedge clk);
      reset = 1'b1;
      load_word(16'd4095, 16'hDEAD);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (mrw) seen = 1'b1;
      end
      chk("push_write_seen", 32'(seen), 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_mrw_now", 32'(mrw), 32'd0);
      @(posedge clk); #1;
      chk("abort_no_write", 32'(mem[4095]), 32'h0000DEAD);

      for (int p = 0; p < 6; p++) begin
         build_random(40);
         run_prog(mmax_opts[p % 3]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
